// File: rtl/operand_fetch_ctrl_if.sv
// ============================================================================
// Module   : operand_fetch_ctrl_if
// Brief    : Instruction, register-file, write-back and operand bundle of the
//            operand fetch controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface operand_fetch_ctrl_if #(
   parameter int N            = 32,
   parameter int address_size = 5
);
   logic                    instr_valid;
   logic [31:0]             instr;
   logic                    instr_ready;
   logic [address_size-1:0] rs_address;
   logic [address_size-1:0] rt_address;
   logic [N-1:0]            reg_A;
   logic [N-1:0]            reg_B;
   logic                    wb_valid;
   logic [address_size-1:0] wb_addr;
   logic [N-1:0]            wb_data;
   logic [address_size-1:0] rd_address;
   logic [N-1:0]            write_data;
   logic                    Regwrite;
   logic                    op_valid;
   logic                    op_ready;
   logic [N-1:0]            opA;
   logic [N-1:0]            opB;
   logic [N-1:0]            op_imm;
   logic [address_size-1:0] op_dest;
   logic [31:0]             op_instr;

   modport master (
      input  instr_valid, instr, reg_A, reg_B, wb_valid, wb_addr, wb_data, op_ready,
      output instr_ready, rs_address, rt_address, rd_address, write_data, Regwrite,
             op_valid, opA, opB, op_imm, op_dest, op_instr
   );

   modport slave (
      output instr_valid, instr, reg_A, reg_B, wb_valid, wb_addr, wb_data, op_ready,
      input  instr_ready, rs_address, rt_address, rd_address, write_data, Regwrite,
             op_valid, opA, opB, op_imm, op_dest, op_instr
   );
endinterface

`default_nettype wire

// File: rtl/operand_fetch_ctrl.sv
// ============================================================================
// Module   : operand_fetch_ctrl
// Brief    : Latches a MIPS instruction, fetches its operands with write-back
//            bypass and presents them to the ALU stage with valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_fetch_ctrl #(
   parameter int N            = 32,
   parameter int address_size = 5
) (
   input  wire logic             clk,
   input  wire logic             reset,
   operand_fetch_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      CAPT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t                  state_q;
   logic [31:0]             ir_q;
   logic                    instr_ready_q;
   logic                    op_valid_q;
   logic [N-1:0]            opa_q;
   logic [N-1:0]            opb_q;
   logic [N-1:0]            imm_q;
   logic [address_size-1:0] dest_q;
   logic [31:0]             op_instr_q;
   logic                    byp_a_vld_q;
   logic                    byp_b_vld_q;
   logic [N-1:0]            byp_a_q;
   logic [N-1:0]            byp_b_q;

   logic [address_size-1:0] rs;
   logic [address_size-1:0] rt;
   logic                    regwrite;
   logic [N-1:0]            opa_d;
   logic [N-1:0]            opb_d;

   assign rs       = address_size'(ir_q[25:21]);
   assign rt       = address_size'(ir_q[20:16]);
   assign regwrite = bus.wb_valid && (bus.wb_addr != '0);

   // Source resolution order: $0 forces zero, then a same-cycle write, then a
   // write seen during READ, finally the register-file read data.
   always_comb begin
      opa_d = bus.reg_A;
      if (byp_a_vld_q)                         opa_d = byp_a_q;
      if (regwrite && (bus.wb_addr == rs))     opa_d = bus.wb_data;
      if (rs == '0)                            opa_d = '0;
      opb_d = bus.reg_B;
      if (byp_b_vld_q)                         opb_d = byp_b_q;
      if (regwrite && (bus.wb_addr == rt))     opb_d = bus.wb_data;
      if (rt == '0)                            opb_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ir_q          <= '0;
         instr_ready_q <= 1'b1;
         op_valid_q    <= 1'b0;
         opa_q         <= '0;
         opb_q         <= '0;
         imm_q         <= '0;
         dest_q        <= '0;
         op_instr_q    <= '0;
         byp_a_vld_q   <= 1'b0;
         byp_b_vld_q   <= 1'b0;
         byp_a_q       <= '0;
         byp_b_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.instr_valid) begin
                  ir_q          <= bus.instr;
                  instr_ready_q <= 1'b0;
                  byp_a_vld_q   <= 1'b0;
                  byp_b_vld_q   <= 1'b0;
                  state_q       <= READ;
               end
            end
            READ: begin
               if (regwrite && (bus.wb_addr == rs)) begin
                  byp_a_vld_q <= 1'b1;
                  byp_a_q     <= bus.wb_data;
               end
               if (regwrite && (bus.wb_addr == rt)) begin
                  byp_b_vld_q <= 1'b1;
                  byp_b_q     <= bus.wb_data;
               end
               state_q <= CAPT;
            end
            CAPT: begin
               opa_q      <= opa_d;
               opb_q      <= opb_d;
               imm_q      <= N'($signed(ir_q[15:0]));
               dest_q     <= (ir_q[31:26] == 6'd0) ? address_size'(ir_q[15:11]) : rt;
               op_instr_q <= ir_q;
               op_valid_q <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               if (bus.op_ready) begin
                  op_valid_q    <= 1'b0;
                  instr_ready_q <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.instr_ready = instr_ready_q;
   assign bus.rs_address  = rs;
   assign bus.rt_address  = rt;
   assign bus.rd_address  = bus.wb_addr;
   assign bus.write_data  = bus.wb_data;
   assign bus.Regwrite    = regwrite;
   assign bus.op_valid    = op_valid_q;
   assign bus.opA         = opa_q;
   assign bus.opB         = opb_q;
   assign bus.op_imm      = imm_q;
   assign bus.op_dest     = dest_q;
   assign bus.op_instr    = op_instr_q;

endmodule

`default_nettype wire
